// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for the immediate generator: instruction beats in, immediate beats out.
// The stage uses the slave view; whoever drives instructions and consumes immediates uses master.
interface imm_gen_stage_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
   logic [2:0]      fmt;

   modport master (
      output flush, in_valid, instr, out_ready,
      input  in_ready, out_valid, imm, fmt
   );

   modport slave (
      input  flush, in_valid, instr, out_ready,
      output in_ready, out_valid, imm, fmt
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate generator with a one-entry skid buffer.
// Each accepted instruction produces its extended immediate and format code one cycle later.
module imm_gen_stage #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   imm_gen_stage_if.slave bus
);

   typedef enum logic [2:0] {
      FMT_I   = 3'd0,
      FMT_S   = 3'd1,
      FMT_B   = 3'd2,
      FMT_U   = 3'd3,
      FMT_J   = 3'd4,
      FMT_SH  = 3'd5,
      FMT_Z   = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [31:0]     ins;
   logic [XLEN-1:0] decImm;
   fmt_e            decFmt;

   logic            outValidQ, outValidD;
   logic [XLEN-1:0] immQ, immD;
   fmt_e            fmtQ, fmtD;
   logic            skidValidQ, skidValidD;
   logic [XLEN-1:0] skidImmQ, skidImmD;
   fmt_e            skidFmtQ, skidFmtD;

   logic            inReady;
   logic            accept;
   logic            outFree;

   assign ins = bus.instr;

   // Pure decode of the incoming word; bit 31 is the sign for every signed format.
   always_comb begin
      decImm = '0;
      decFmt = FMT_ILL;
      case (ins[6:0])
         OP_LOAD, OP_JALR: begin
            decFmt = FMT_I;
            decImm = {{(XLEN-12){ins[31]}}, ins[31:20]};
         end
         OP_IMM: begin
            if (ins[13:12] == 2'b01) begin
               if (XLEN == 32) begin
                  if (!ins[25]) begin
                     decFmt      = FMT_SH;
                     decImm[4:0] = ins[24:20];
                  end
               end else begin
                  decFmt      = FMT_SH;
                  decImm[5:0] = ins[25:20];
               end
            end else begin
               decFmt = FMT_I;
               decImm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
         end
         OP_STORE: begin
            decFmt = FMT_S;
            decImm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
         end
         OP_BRANCH: begin
            decFmt = FMT_B;
            decImm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            decFmt = FMT_U;
            decImm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'h000};
         end
         OP_JAL: begin
            decFmt = FMT_J;
            decImm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         OP_SYSTEM: begin
            if (ins[14] && (ins[13:12] != 2'b00)) begin
               decFmt      = FMT_Z;
               decImm[4:0] = ins[19:15];
            end else begin
               decFmt = FMT_I;
               decImm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
         end
         default: begin
            decFmt = FMT_ILL;
            decImm = '0;
         end
      endcase
   end

   // With the skid present, in_ready comes straight from a flop and never sees out_ready.
   assign inReady = SKID_EN ? !skidValidQ : (!outValidQ || bus.out_ready);
   assign accept  = bus.in_valid && inReady;
   assign outFree = !outValidQ || bus.out_ready;

   // Next-state: flush wins, then a draining output refills from the skid first to keep order.
   always_comb begin
      outValidD  = outValidQ;
      immD       = immQ;
      fmtD       = fmtQ;
      skidValidD = skidValidQ;
      skidImmD   = skidImmQ;
      skidFmtD   = skidFmtQ;
      if (bus.flush) begin
         outValidD  = 1'b0;
         skidValidD = 1'b0;
      end else if (outFree) begin
         if (skidValidQ) begin
            outValidD  = 1'b1;
            immD       = skidImmQ;
            fmtD       = skidFmtQ;
            skidValidD = 1'b0;
         end else if (accept) begin
            outValidD = 1'b1;
            immD      = decImm;
            fmtD      = decFmt;
         end else begin
            outValidD = 1'b0;
         end
      end else if (accept && SKID_EN) begin
         skidValidD = 1'b1;
         skidImmD   = decImm;
         skidFmtD   = decFmt;
      end
   end

   // State registers; reset leaves the output showing an illegal, zero immediate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValidQ  <= 1'b0;
         immQ       <= '0;
         fmtQ       <= FMT_ILL;
         skidValidQ <= 1'b0;
         skidImmQ   <= '0;
         skidFmtQ   <= FMT_ILL;
      end else begin
         outValidQ  <= outValidD;
         immQ       <= immD;
         fmtQ       <= fmtD;
         skidValidQ <= skidValidD;
         skidImmQ   <= skidImmD;
         skidFmtQ   <= skidFmtD;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValidQ;
   assign bus.imm       = immQ;
   assign bus.fmt       = fmtQ;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: a 32-bit and a 64-bit instance share clock and reset.
// Expected immediates are pushed when a beat is accepted and popped when the output transfers.
module tb_imm_gen_stage;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] imm;
      logic [2:0]  fmt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;
   exp_t sb32[$];
   exp_t sb64[$];

   imm_gen_stage_if #(.XLEN(32)) bus32();
   imm_gen_stage_if #(.XLEN(64)) bus64();

   imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   imm_gen_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus64.slave)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.instr = '0; bus32.out_ready = 1'b0;
      bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.instr = '0; bus64.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus32.out_valid !== 1'b0 || bus32.imm !== 32'h0 || bus32.fmt !== 3'd7)
         $display("[TB] FAIL reset_state got v=%b imm=%h fmt=%0d exp v=0 imm=0 fmt=7",
                  bus32.out_valid, bus32.imm, bus32.fmt);
      else passes++;
      checks++;
      if (bus64.out_valid !== 1'b0 || bus64.imm !== 64'h0 || bus64.fmt !== 3'd7)
         $display("[TB] FAIL reset_state64 got v=%b imm=%h fmt=%0d exp v=0 imm=0 fmt=7",
                  bus64.out_valid, bus64.imm, bus64.fmt);
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0)
         $display("[TB] FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0",
                  bus32.in_ready, bus32.out_valid);
      else passes++;
   endtask

   task automatic test_back_to_back();
      vec_t tbl[14];
      exp_t e;
      int   got = 0;
      tbl = '{
         '{32'h0080af03, 64'h00000008, 3'd0},
         '{32'hff80af03, 64'hFFFFFFF8, 3'd0},
         '{32'h0200a283, 64'h00000020, 3'd0},
         '{32'hfe20aa23, 64'hFFFFFFF4, 3'd1},
         '{32'h0020a223, 64'h00000004, 3'd1},
         '{32'hfeb289e3, 64'hFFFFFFF2, 3'd2},
         '{32'h00208463, 64'h00000008, 3'd2},
         '{32'h123452b7, 64'h12345000, 3'd3},
         '{32'h008000ef, 64'h00000008, 3'd4},
         '{32'h00309093, 64'h00000003, 3'd5},
         '{32'h4030d093, 64'h00000003, 3'd5},
         '{32'h02009093, 64'h00000000, 3'd7},
         '{32'h3401d073, 64'h00000003, 3'd6},
         '{32'hffffffff, 64'h00000000, 3'd7}
      };
      bus32.out_ready = 1'b1;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         checks++;
         if (bus32.out_valid !== ((c >= 1) && (c <= 14)))
            $display("[TB] FAIL b2b_valid cycle %0d got %b exp %b", c, bus32.out_valid,
                     ((c >= 1) && (c <= 14)));
         else passes++;
         if (bus32.out_valid && bus32.out_ready) begin
            got++;
            checks++;
            if (sb32.size() == 0)
               $display("[TB] FAIL b2b_extra got imm=%h with no beat expected", bus32.imm);
            else begin
               e = sb32.pop_front();
               if (bus32.imm !== e.imm[31:0] || bus32.fmt !== e.fmt)
                  $display("[TB] FAIL b2b_data cycle %0d got imm=%h fmt=%0d exp imm=%h fmt=%0d",
                           c, bus32.imm, bus32.fmt, e.imm[31:0], e.fmt);
               else passes++;
            end
         end
         if (c < 14) begin
            bus32.in_valid = 1'b1;
            bus32.instr    = tbl[c].instr;
            checks++;
            if (bus32.in_ready !== 1'b1)
               $display("[TB] FAIL b2b_in_ready cycle %0d got %b exp 1", c, bus32.in_ready);
            else passes++;
            if (bus32.in_ready) begin
               e.imm = tbl[c].imm;
               e.fmt = tbl[c].fmt;
               sb32.push_back(e);
            end
         end else begin
            bus32.in_valid = 1'b0;
         end
      end
      checks++;
      if (got != 14) $display("[TB] FAIL b2b_count got %0d exp 14", got);
      else passes++;
   endtask

   task automatic test_backpressure();
      vec_t tbl[3];
      exp_t e;
      int   sent = 0;
      int   got  = 0;
      tbl = '{
         '{32'h0080af03, 64'h00000008, 3'd0},
         '{32'hfe20aa23, 64'hFFFFFFF4, 3'd1},
         '{32'h123452b7, 64'h12345000, 3'd3}
      };
      sb32.delete();
      for (int c = 0; c < 30 && got < 3; c++) begin
         @(negedge clk);
         bus32.out_ready = (c >= 6);
         if (c >= 2 && c <= 5) begin
            checks++;
            if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 ||
                bus32.imm !== 32'h00000008 || bus32.fmt !== 3'd0)
               $display("[TB] FAIL bp_stall cycle %0d got rdy=%b v=%b imm=%h fmt=%0d exp rdy=0 v=1 imm=00000008 fmt=0",
                        c, bus32.in_ready, bus32.out_valid, bus32.imm, bus32.fmt);
            else passes++;
         end
         if (bus32.out_valid && bus32.out_ready) begin
            got++;
            checks++;
            if (sb32.size() == 0)
               $display("[TB] FAIL bp_extra got imm=%h with no beat expected", bus32.imm);
            else begin
               e = sb32.pop_front();
               if (bus32.imm !== e.imm[31:0] || bus32.fmt !== e.fmt)
                  $display("[TB] FAIL bp_order beat %0d got imm=%h fmt=%0d exp imm=%h fmt=%0d",
                           got, bus32.imm, bus32.fmt, e.imm[31:0], e.fmt);
               else passes++;
            end
         end
         if (sent < 3) begin
            bus32.in_valid = 1'b1;
            bus32.instr    = tbl[sent].instr;
            if (bus32.in_ready) begin
               e.imm = tbl[sent].imm;
               e.fmt = tbl[sent].fmt;
               sb32.push_back(e);
               sent++;
            end
         end else begin
            bus32.in_valid = 1'b0;
         end
      end
      bus32.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (got != 3 || sent != 3 || bus32.out_valid !== 1'b0)
         $display("[TB] FAIL bp_count got out=%0d in=%0d v=%b exp out=3 in=3 v=0",
                  got, sent, bus32.out_valid);
      else passes++;
   endtask

   task automatic test_flush();
      sb32.delete();
      bus32.out_ready = 1'b0;
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.instr    = 32'h0200a283;
      @(negedge clk);
      bus32.instr    = 32'h00208463;
      @(negedge clk);
      checks++;
      if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1)
         $display("[TB] FAIL flush_setup got rdy=%b v=%b exp rdy=0 v=1", bus32.in_ready, bus32.out_valid);
      else passes++;
      bus32.instr = 32'h008000ef;
      bus32.flush = 1'b1;
      @(negedge clk);
      bus32.flush    = 1'b0;
      bus32.in_valid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1)
         $display("[TB] FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", bus32.out_valid, bus32.in_ready);
      else passes++;
      bus32.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (bus32.out_valid !== 1'b0)
            $display("[TB] FAIL flush_leak cycle %0d got v=%b imm=%h exp v=0", c, bus32.out_valid, bus32.imm);
         else passes++;
      end
      bus32.in_valid = 1'b1;
      bus32.instr    = 32'h00309093;
      bus32.flush    = 1'b1;
      @(negedge clk);
      bus32.flush    = 1'b0;
      bus32.in_valid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b0)
         $display("[TB] FAIL flush_drop got v=%b imm=%h exp v=0", bus32.out_valid, bus32.imm);
      else passes++;
   endtask

   task automatic test_xlen64();
      vec_t tbl[4];
      exp_t e;
      int   got = 0;
      tbl = '{
         '{32'h02009093, 64'h0000000000000020, 3'd5},
         '{32'h800002b7, 64'hFFFFFFFF80000000, 3'd3},
         '{32'hff80af03, 64'hFFFFFFFFFFFFFFF8, 3'd0},
         '{32'h4030d093, 64'h0000000000000003, 3'd5}
      };
      sb64.delete();
      bus64.out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (bus64.out_valid && bus64.out_ready) begin
            got++;
            checks++;
            if (sb64.size() == 0)
               $display("[TB] FAIL x64_extra got imm=%h with no beat expected", bus64.imm);
            else begin
               e = sb64.pop_front();
               if (bus64.imm !== e.imm || bus64.fmt !== e.fmt)
                  $display("[TB] FAIL x64_data cycle %0d got imm=%h fmt=%0d exp imm=%h fmt=%0d",
                           c, bus64.imm, bus64.fmt, e.imm, e.fmt);
               else passes++;
            end
         end
         if (c < 4) begin
            bus64.in_valid = 1'b1;
            bus64.instr    = tbl[c].instr;
            if (bus64.in_ready) begin
               e.imm = tbl[c].imm;
               e.fmt = tbl[c].fmt;
               sb64.push_back(e);
            end
         end else begin
            bus64.in_valid = 1'b0;
         end
      end
      checks++;
      if (got != 4) $display("[TB] FAIL x64_count got %0d exp 4", got);
      else passes++;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      sb32.delete();
      bus32.out_ready = 1'b0;
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.instr    = 32'hff80af03;
      @(negedge clk);
      bus32.instr    = 32'hfe20aa23;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0)
         $display("[TB] FAIL rstmid_setup got v=%b rdy=%b exp v=1 rdy=0", bus32.out_valid, bus32.in_ready);
      else passes++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus32.imm !== 32'h0 || bus32.fmt !== 3'd7 || bus32.in_ready !== 1'b1)
         $display("[TB] FAIL rstmid_async got v=%b imm=%h fmt=%0d rdy=%b exp v=0 imm=0 fmt=7 rdy=1",
                  bus32.out_valid, bus32.imm, bus32.fmt, bus32.in_ready);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus32.out_valid !== 1'b0)
         $display("[TB] FAIL rstmid_lost got v=%b imm=%h exp v=0", bus32.out_valid, bus32.imm);
      else passes++;
      bus32.out_ready = 1'b1;
      bus32.in_valid  = 1'b1;
      bus32.instr     = 32'h00000013;
      if (bus32.in_ready) begin
         e.imm = 64'h0;
         e.fmt = 3'd0;
         sb32.push_back(e);
      end
      @(negedge clk);
      bus32.in_valid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b1 || sb32.size() == 0)
         $display("[TB] FAIL rstmid_nop_valid got v=%b queued=%0d exp v=1 queued=1",
                  bus32.out_valid, sb32.size());
      else begin
         e = sb32.pop_front();
         if (bus32.imm !== e.imm[31:0] || bus32.fmt !== e.fmt)
            $display("[TB] FAIL rstmid_nop got imm=%h fmt=%0d exp imm=%h fmt=%0d",
                     bus32.imm, bus32.fmt, e.imm[31:0], e.fmt);
         else passes++;
      end
      @(negedge clk);
      checks++;
      if (bus32.out_valid !== 1'b0)
         $display("[TB] FAIL rstmid_tail got v=%b imm=%h exp v=0", bus32.out_valid, bus32.imm);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_xlen64();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
